// File: rtl/fbuf_bank_arbiter.sv
// Double-buffered frame buffer write scheduler: streams capture-FIFO pixels into the
// write bank and hands the finished frame to the display at the next vsync.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RUN       | popping the FIFO and writing the current frame
// WAIT_SWAP | frame fully written, holding until the display vsync

module fbuf_bank_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_PIXELS = 230400,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    input  logic                  i_almostempty,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_wr,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wbank,
    input  logic                  i_disp_vsync,
    output logic                  o_rbank,
    output logic                  o_frame_done,
    output logic                  o_swap,
    output logic [7:0]            o_frame_cnt
);

    typedef enum logic {
        RUN       = 1'b0,
        WAIT_SWAP = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] FRAME_END = ADDR_WIDTH'(FRAME_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic                  rd_q;
    logic                  last_wr;
    logic                  do_swap;

    assign o_rd    = (state == RUN) && !i_almostempty && (rd_cnt != FRAME_END) && !i_flush;
    assign last_wr = rd_q && (wr_cnt == LAST_ADDR) && !i_flush;
    assign do_swap = (state == WAIT_SWAP) && i_disp_vsync && !i_flush;

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:       if (last_wr) state_nxt = WAIT_SWAP;
                WAIT_SWAP: if (i_disp_vsync) state_nxt = RUN;
                default:   state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            rd_q         <= 1'b0;
            o_wr         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_wbank      <= 1'b0;
            o_rbank      <= 1'b1;
            o_frame_done <= 1'b0;
            o_swap       <= 1'b0;
            o_frame_cnt  <= 8'd0;
        end else begin
            rd_q         <= o_rd;
            o_frame_done <= last_wr;
            o_swap       <= do_swap;
            if (i_flush) begin
                // the word popped last cycle is dropped along with the partial frame
                rd_cnt <= '0;
                wr_cnt <= '0;
                o_wr   <= 1'b0;
            end else begin
                if (do_swap) begin
                    rd_cnt      <= '0;
                    wr_cnt      <= '0;
                    o_rbank     <= o_wbank;
                    o_wbank     <= ~o_wbank;
                    o_frame_cnt <= o_frame_cnt + 8'd1;
                end else if (o_rd) begin
                    rd_cnt <= rd_cnt + CNT_ONE;
                end
                // rd_q is never set in WAIT_SWAP, so this cannot collide with a swap
                if (rd_q) begin
                    o_wr    <= 1'b1;
                    o_wdata <= i_rdata;
                    o_waddr <= wr_cnt;
                    wr_cnt  <= wr_cnt + CNT_ONE;
                end else begin
                    o_wr <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fbuf_bank_arbiter.sv
// Self-checking bench for fbuf_bank_arbiter with a 16-pixel frame: a pop/write
// scoreboard runs every cycle, frame/swap scenarios come from a table plus corner sequences.

module tb_fbuf_bank_arbiter;

    localparam int DW = 16;
    localparam int FP = 16;
    localparam int AW = 5;
    localparam logic [AW-1:0] LAST = AW'(FP - 1);

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_flush;
    logic          i_almostempty;
    logic          o_rd;
    logic [DW-1:0] i_rdata;
    logic          o_wr;
    logic [AW-1:0] o_waddr;
    logic [DW-1:0] o_wdata;
    logic          o_wbank;
    logic          i_disp_vsync;
    logic          o_rbank;
    logic          o_frame_done;
    logic          o_swap;
    logic [7:0]    o_frame_cnt;

    fbuf_bank_arbiter #(
        .DATA_WIDTH  (DW),
        .FRAME_PIXELS(FP),
        .ADDR_WIDTH  (AW)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_flush      (i_flush),
        .i_almostempty(i_almostempty),
        .o_rd         (o_rd),
        .i_rdata      (i_rdata),
        .o_wr         (o_wr),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_wbank      (o_wbank),
        .i_disp_vsync (i_disp_vsync),
        .o_rbank      (o_rbank),
        .o_frame_done (o_frame_done),
        .o_swap       (o_swap),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        bit         bursty;
        int         vs_delay;
        logic       wbank;
        logic       rbank;
        logic [7:0] fcnt;
    } row_t;

    sb_t           sb_q[$];
    row_t          rows[3];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            wr_seen  = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [AW-1:0] first_addr = '0;
    logic          m_wbank  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample inputs, advance past the edge, then score the DUT outputs.
    task automatic tick();
        logic rd_now, fl_now, rst_now, ae_now, exp_wr, exp_done;
        sb_t  e;
        #1;
        rd_now  = o_rd;
        fl_now  = i_flush;
        rst_now = !i_rstn;
        ae_now  = i_almostempty;
        @(posedge i_clk);
        #1;
        cyc++;
        if (rst_now || fl_now) begin
            sb_q.delete();
            exp_addr = '0;
        end
        if (rst_now) m_wbank = 1'b0;
        chk("rd_while_empty", 32'(rd_now && ae_now), 0);
        exp_wr   = (sb_q.size() != 0);
        exp_done = 1'b0;
        chk("wr_strobe", 32'(o_wr), 32'(exp_wr));
        if (exp_wr) begin
            e = sb_q.pop_front();
            chk("waddr", 32'(o_waddr), 32'(e.addr));
            chk("wdata", 32'(o_wdata), 32'(e.data));
            chk("wbank_on_wr", 32'(o_wbank), 32'(m_wbank));
            exp_done = (e.addr == LAST);
            if (wr_seen == 0) first_addr = o_waddr;
            wr_seen++;
        end
        chk("frame_done", 32'(o_frame_done), 32'(exp_done));
        chk("bank_excl", 32'(o_wbank != o_rbank), 1);
        if (rd_now && !rst_now) begin
            e.addr  = exp_addr;
            e.data  = DW'($urandom_range(0, 65535));
            i_rdata = e.data;
            sb_q.push_back(e);
            exp_addr = (exp_addr == LAST) ? '0 : exp_addr + 1'b1;
        end
    endtask

    task automatic run_frame(input bit bursty);
        bit done_seen;
        done_seen = 1'b0;
        for (int i = 0; i < 200 && !done_seen; i++) begin
            i_almostempty = bursty ? ((cyc % 5) < 3) : 1'b0;
            tick();
            if (o_frame_done) done_seen = 1'b1;
        end
        i_almostempty = 1'b0;
        chk("frame_complete", 32'(done_seen), 1);
    endtask

    task automatic wait_addr(input logic [AW-1:0] a);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            if (o_wr && o_waddr == a) hit = 1'b1;
        end
        chk("reach_addr", 32'(hit), 1);
    endtask

    task automatic check_banks(input string name, input logic sw, input logic w, input logic r,
                               input logic [7:0] c);
        chk({name, "_swap"}, 32'(o_swap), 32'(sw));
        chk({name, "_wbank"}, 32'(o_wbank), 32'(w));
        chk({name, "_rbank"}, 32'(o_rbank), 32'(r));
        chk({name, "_fcnt"}, 32'(o_frame_cnt), 32'(c));
    endtask

    task automatic do_swap(input logic w, input logic r, input logic [7:0] c);
        i_disp_vsync = 1'b1;
        tick();
        i_disp_vsync = 1'b0;
        check_banks("swap", 1'b1, w, r, c);
        m_wbank = w;
    endtask

    initial begin
        rows[0] = '{bursty: 1'b0, vs_delay: 5, wbank: 1'b1, rbank: 1'b0, fcnt: 8'd1};
        rows[1] = '{bursty: 1'b1, vs_delay: 2, wbank: 1'b0, rbank: 1'b1, fcnt: 8'd2};
        rows[2] = '{bursty: 1'b0, vs_delay: 0, wbank: 1'b1, rbank: 1'b0, fcnt: 8'd3};

        i_rstn        = 1'b0;
        i_flush       = 1'b0;
        i_almostempty = 1'b1;
        i_disp_vsync  = 1'b0;
        i_rdata       = '0;
        tick();
        tick();
        chk("rst_wr", 32'(o_wr), 0);
        chk("rst_waddr", 32'(o_waddr), 0);
        chk("rst_wdata", 32'(o_wdata), 0);
        chk("rst_done", 32'(o_frame_done), 0);
        check_banks("rst", 1'b0, 1'b0, 1'b1, 8'd0);
        i_rstn        = 1'b1;
        i_almostempty = 1'b0;

        for (int r = 0; r < 3; r++) begin
            wr_seen = 0;
            run_frame(rows[r].bursty);
            chk("row_writes", wr_seen, FP);
            chk("row_first_addr", 32'(first_addr), 0);
            for (int d = 0; d < rows[r].vs_delay; d++) begin
                tick();
                chk("rd_in_wait", 32'(o_rd), 0);
                chk("no_swap_in_wait", 32'(o_swap), 0);
            end
            do_swap(rows[r].wbank, rows[r].rbank, rows[r].fcnt);
            tick();
            chk("swap_pulse_len", 32'(o_swap), 0);
        end

        // vsync mid-frame and on the final-write edge are both ignored
        wr_seen = 0;
        wait_addr(AW'(7));
        i_disp_vsync = 1'b1;
        tick();
        i_disp_vsync = 1'b0;
        check_banks("vs_mid", 1'b0, 1'b1, 1'b0, 8'd3);
        wait_addr(AW'(14));
        i_disp_vsync = 1'b1;
        tick();
        i_disp_vsync = 1'b0;
        chk("coinc_done", 32'(o_frame_done), 1);
        chk("coinc_waddr", 32'(o_waddr), 32'(LAST));
        check_banks("vs_coinc", 1'b0, 1'b1, 1'b0, 8'd3);
        tick();
        check_banks("vs_coinc_next", 1'b0, 1'b1, 1'b0, 8'd3);
        chk("coinc_rd_idle", 32'(o_rd), 0);
        chk("coinc_writes", wr_seen, FP);
        do_swap(1'b0, 1'b1, 8'd4);

        // flush with a word in flight, then flush+vsync while waiting to swap
        wr_seen = 0;
        wait_addr(AW'(9));
        i_flush = 1'b1;
        #1;
        chk("rd_in_flush", 32'(o_rd), 0);
        tick();
        i_flush = 1'b0;
        chk("wr_after_flush", 32'(o_wr), 0);
        check_banks("flush_run", 1'b0, 1'b0, 1'b1, 8'd4);
        wr_seen = 0;
        run_frame(1'b0);
        chk("flush_writes", wr_seen, FP);
        chk("flush_first_addr", 32'(first_addr), 0);
        i_flush      = 1'b1;
        i_disp_vsync = 1'b1;
        tick();
        i_flush      = 1'b0;
        i_disp_vsync = 1'b0;
        check_banks("flush_vs", 1'b0, 1'b0, 1'b1, 8'd4);
        wr_seen = 0;
        run_frame(1'b0);
        chk("rewrite_writes", wr_seen, FP);
        chk("rewrite_first_addr", 32'(first_addr), 0);
        do_swap(1'b1, 1'b0, 8'd5);

        // one-cycle reset in the middle of a frame
        wr_seen = 0;
        wait_addr(AW'(5));
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
        chk("mrst_wr", 32'(o_wr), 0);
        chk("mrst_waddr", 32'(o_waddr), 0);
        chk("mrst_wdata", 32'(o_wdata), 0);
        chk("mrst_done", 32'(o_frame_done), 0);
        check_banks("mrst", 1'b0, 1'b0, 1'b1, 8'd0);
        wr_seen = 0;
        run_frame(1'b0);
        chk("mrst_writes", wr_seen, FP);
        chk("mrst_first_addr", 32'(first_addr), 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
